// File: rtl/apb_multi_slave_master.sv
`timescale 1ns/1ps
// Buffered APB4 master: request FIFO, address decode to NO_OF_SLAVES selects and SETUP/ACCESS sequencing.
// Push-to-response latency is 3 cycles with no wait states. req_ready drops when the FIFO is full.
module apb_multi_slave_master #(
  parameter int NO_OF_SLAVES   = 4,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BUFFER_DEPTH   = 8,
  parameter int SLAVE_ADDR_LSB = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                               pclk,
  input  logic                               preset,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic                               req_write,
  input  logic [ADDRESS_WIDTH-1:0]           req_addr,
  input  logic [DATA_WIDTH-1:0]              req_wdata,
  input  logic [DATA_WIDTH/8-1:0]            req_strb,
  input  logic [2:0]                         req_prot,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [DATA_WIDTH-1:0]              rsp_rdata,
  output logic [1:0]                         rsp_status,
  output logic [$clog2(BUFFER_DEPTH):0]      fifo_level,
  output logic [NO_OF_SLAVES-1:0]            psel,
  output logic                               penable,
  output logic                               pwrite,
  output logic [ADDRESS_WIDTH-1:0]           paddr,
  output logic [DATA_WIDTH-1:0]              pwdata,
  output logic [DATA_WIDTH/8-1:0]            pstrb,
  output logic [2:0]                         pprot,
  input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] prdata,
  input  logic [NO_OF_SLAVES-1:0]            pready,
  input  logic [NO_OF_SLAVES-1:0]            pslverr
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam logic [PW:0] DEPTH = BUFFER_DEPTH[PW:0];
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] ST_OK = 2'b00, ST_SLVERR = 2'b01, ST_DECERR = 2'b10, ST_TIMEOUT = 2'b11;

  typedef struct packed {
    logic                     write;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [SW-1:0]            strb;
    logic [2:0]               prot;
  } req_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state, state_nxt;
  req_t                    mem [BUFFER_DEPTH];
  req_t                    head;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [PW:0]             count;
  logic                    push, pop, full, empty;
  logic [3:0]              head_idx, idx_r;
  logic                    head_dec_ok;
  logic [NO_OF_SLAVES-1:0] sel_vec;
  logic                    sel_ready, sel_err, timed_out;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic [31:0]             wait_cnt;

  assign full       = (count == DEPTH);
  assign empty      = (count == '0);
  assign req_ready  = !full;
  assign push       = req_valid && !full;
  assign pop        = (state == IDLE) && !empty;
  assign head       = mem[rd_ptr];
  assign fifo_level = count;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr] <= '{req_write, req_addr, req_wdata, req_strb, req_prot};
  end

  assign head_idx    = head.addr[SLAVE_ADDR_LSB+3:SLAVE_ADDR_LSB];
  assign head_dec_ok = ({1'b0, head_idx} < 5'(NO_OF_SLAVES));

  // Only the addressed slave's handshake is looked at; the rest of the fabric is ignored.
  assign sel_vec   = NO_OF_SLAVES'(1) << idx_r;
  assign sel_ready = |(pready & sel_vec);
  assign sel_err   = |(pslverr & sel_vec);
  assign timed_out = (TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LAST);

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NO_OF_SLAVES; k++) begin
      if (idx_r == 4'(k)) sel_rdata = prdata[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    psel      = '0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE:   if (!empty) state_nxt = head_dec_ok ? SETUP : RESP;
      SETUP: begin
        psel      = sel_vec;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = sel_vec;
        penable = 1'b1;
        if (sel_ready || timed_out) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      paddr      <= '0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
      pstrb      <= '0;
      pprot      <= '0;
      idx_r      <= '0;
      wait_cnt   <= '0;
      rsp_rdata  <= '0;
      rsp_status <= ST_OK;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            // A decode miss never reaches the bus, so the bus fields keep their old values.
            if (head_dec_ok) begin
              paddr  <= head.addr;
              pwrite <= head.write;
              pwdata <= head.wdata;
              pstrb  <= head.write ? head.strb : '0;
              pprot  <= head.prot;
              idx_r  <= head_idx;
            end else begin
              rsp_status <= ST_DECERR;
              rsp_rdata  <= '0;
            end
          end
        end
        SETUP: wait_cnt <= '0;
        ACCESS: begin
          wait_cnt <= wait_cnt + 32'd1;
          if (sel_ready) begin
            rsp_status <= sel_err ? ST_SLVERR : ST_OK;
            rsp_rdata  <= (!pwrite && !sel_err) ? sel_rdata : '0;
          end else if (timed_out) begin
            rsp_status <= ST_TIMEOUT;
            rsp_rdata  <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
